// File: rtl/mem_pkg.sv
// Shared types for the block-RAM port arbiter: default RAM geometry,
// arbitration state, requester id and the in-flight response tag.
package mem_pkg;

    localparam int MEM_ADDR_WIDTH = 16;
    localparam int MEM_DATA_WIDTH = 32;

    typedef enum logic {
        ARB_OPEN,
        ARB_LOCKED
    } arb_state_t;

    // 0 = evaluator core, 1 = garbage collector / loader
    typedef logic port_id_t;

    typedef struct packed {
        logic     valid;
        port_id_t id;
    } resp_tag_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port, 1-cycle-latency RAM,
// with an owner lock for atomic read-modify-write sequences.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int LOCK_MAX   = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [1:0]                req_we,
    input  logic [1:0]                req_lock,
    input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]                resp_valid,
    output logic [DATA_WIDTH-1:0]     resp_rdata,
    output logic                      ram_we,
    output logic [ADDR_WIDTH-1:0]     ram_addr,
    output logic [DATA_WIDTH-1:0]     ram_wdata,
    input  logic [DATA_WIDTH-1:0]     ram_rdata
);

    localparam int CNT_W = $clog2(LOCK_MAX + 2);

    arb_state_t       state_q, state_d;
    port_id_t         owner_q, owner_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    resp_tag_t        tag_q, tag_d;

    logic             xfer;
    port_id_t         gnt_port;
    logic [CNT_W-1:0] cnt_inc;
    logic             limit_hit;

    always_comb begin
        req_ready = 2'b00;
        if (!rst) begin
            if (state_q == ARB_LOCKED) begin
                req_ready[owner_q] = req_valid[owner_q];
            end else begin
                case (req_valid)
                    2'b01:   req_ready = 2'b01;
                    2'b10:   req_ready = 2'b10;
                    2'b11:   req_ready = rr_ptr_q ? 2'b10 : 2'b01;
                    default: req_ready = 2'b00;
                endcase
            end
        end

        xfer     = |req_ready;
        gnt_port = req_ready[1];

        ram_we    = xfer & req_we[gnt_port];
        ram_addr  = xfer ? req_addr[gnt_port]  : '0;
        ram_wdata = xfer ? req_wdata[gnt_port] : '0;

        // The acquiring transfer counts as the first granted cycle of a lock.
        cnt_inc   = ((state_q == ARB_LOCKED) ? lock_cnt_q : '0) + 1'b1;
        limit_hit = (LOCK_MAX != 0) && (cnt_inc >= CNT_W'(LOCK_MAX));

        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        lock_cnt_d = lock_cnt_q;
        tag_d      = '{valid: xfer, id: gnt_port};

        if (xfer) begin
            rr_ptr_d = ~gnt_port;
            if (req_lock[gnt_port] && !limit_hit) begin
                state_d    = ARB_LOCKED;
                owner_d    = gnt_port;
                lock_cnt_d = cnt_inc;
            end else begin
                state_d    = ARB_OPEN;
                lock_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_OPEN;
            owner_q    <= 1'b0;
            rr_ptr_q   <= 1'b0;
            lock_cnt_q <= '0;
            tag_q      <= '{valid: 1'b0, id: 1'b0};
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_cnt_q <= lock_cnt_d;
            tag_q      <= tag_d;
        end
    end

    // A response due in a reset cycle is suppressed, not just the next one.
    assign resp_valid = {tag_q.valid & tag_q.id, tag_q.valid & ~tag_q.id} & {2{~rst}};
    assign resp_rdata = ram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomised checks of mem_port_arbiter against a behavioural
// RAM and a request-side shadow memory.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           req_valid, req_ready, req_we, req_lock, resp_valid;
    logic [1:0][AW-1:0]   req_addr;
    logic [1:0][DW-1:0]   req_wdata;
    logic [DW-1:0]        resp_rdata, ram_wdata, ram_rdata;
    logic                 ram_we;
    logic [AW-1:0]        ram_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LOCK_MAX  (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    function automatic logic [DW-1:0] init_word(input int a);
        return {16'hA500, 16'(a)};
    endfunction

    // Behavioural RAM: registered read, read-before-write.
    logic [DW-1:0] ram_mem [65536];
    logic          ram_init_done = 1'b0;

    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < 65536; i++) ram_mem[i] <= init_word(i);
            ram_init_done <= 1'b1;
        end else begin
            ram_rdata <= ram_mem[ram_addr];
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic we, input logic lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd);
        req_valid[p] = v;
        req_we[p]    = we;
        req_lock[p]  = lk;
        req_addr[p]  = a;
        req_wdata[p] = wd;
    endtask

    task automatic idle_all();
        set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // One cycle: check ready/response mid-cycle, then advance past the edge.
    task automatic expect_cyc(input string tag, input logic [1:0] exp_rdy, input logic [1:0] exp_resp,
                              input logic chk_data, input logic [DW-1:0] exp_data);
        @(negedge clk);
        check_eq({tag, "_ready"}, 32'(req_ready), 32'(exp_rdy));
        check_eq({tag, "_resp"}, 32'(resp_valid), 32'(exp_resp));
        if (chk_data) check_eq({tag, "_rdata"}, resp_rdata, exp_data);
        $display("cyc %s ready=%b resp=%b rdata=%h", tag, req_ready, resp_valid, resp_rdata);
        next_cycle();
    endtask

    logic [DW-1:0] shadow [16];
    logic          pend_v;
    logic          pend_port;
    logic [DW-1:0] pend_data;
    logic [1:0]    last_ready;
    logic [1:0]    prev_gnt;
    int            rnd_xfers;

    initial begin
        rst = 1'b1;
        idle_all();
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0001, '0);
        set_req(1, 1'b1, 1'b0, 1'b0, 16'h0002, '0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_ready", 32'(req_ready), 32'h0);
        check_eq("rst_resp", 32'(resp_valid), 32'h0);
        check_eq("rst_ram_we", 32'(ram_we), 32'h0);
        check_eq("rst_ram_addr", 32'(ram_addr), 32'h0);
        next_cycle();
        rst = 1'b0;
        idle_all();

        // Write then read back the same word.
        set_req(0, 1'b1, 1'b1, 1'b0, 16'h0010, 32'hCAFE0001);
        @(negedge clk);
        check_eq("t1_wr_ready", 32'(req_ready), 32'h1);
        check_eq("t1_ram_we", 32'(ram_we), 32'h1);
        check_eq("t1_ram_addr", 32'(ram_addr), 32'h10);
        check_eq("t1_ram_wdata", ram_wdata, 32'hCAFE0001);
        next_cycle();
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0010, '0);
        expect_cyc("t1_rd", 2'b01, 2'b01, 1'b1, 32'hA5000010);
        idle_all();
        expect_cyc("t1_rdresp", 2'b00, 2'b01, 1'b1, 32'hCAFE0001);
        expect_cyc("t1_quiet", 2'b00, 2'b00, 1'b0, '0);

        // Round-robin alternation straight after reset.
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0030, '0);
        set_req(1, 1'b1, 1'b0, 1'b0, 16'h0031, '0);
        prev_gnt = 2'b00;
        for (int i = 0; i < 6; i++) begin
            logic [1:0] exp_g;
            exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
            expect_cyc("t2_rr", exp_g, prev_gnt, prev_gnt != 2'b00,
                       (prev_gnt == 2'b01) ? 32'hA5000030 : 32'hA5000031);
            prev_gnt = exp_g;
        end
        idle_all();
        expect_cyc("t2_last", 2'b00, 2'b10, 1'b1, 32'hA5000031);

        // Port 1 locked read-modify-write blocks port 0.
        set_req(1, 1'b1, 1'b0, 1'b1, 16'h0020, '0);
        expect_cyc("t3_lock", 2'b10, 2'b00, 1'b0, '0);
        set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0040, '0);
        expect_cyc("t3_idle", 2'b00, 2'b10, 1'b1, 32'hA5000020);
        set_req(1, 1'b1, 1'b1, 1'b0, 16'h0020, 32'h12345678);
        expect_cyc("t3_unlock", 2'b10, 2'b00, 1'b0, '0);
        set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
        expect_cyc("t3_p0", 2'b01, 2'b10, 1'b1, 32'hA5000020);
        idle_all();
        expect_cyc("t3_p0resp", 2'b00, 2'b01, 1'b1, 32'hA5000040);

        // Lock limit of 3 transfers, then the other port gets in.
        set_req(0, 1'b1, 1'b0, 1'b1, 16'h0050, '0);
        expect_cyc("t4_a", 2'b01, 2'b00, 1'b0, '0);
        set_req(1, 1'b1, 1'b0, 1'b0, 16'h0051, '0);
        expect_cyc("t4_b", 2'b01, 2'b01, 1'b1, 32'hA5000050);
        expect_cyc("t4_c", 2'b01, 2'b01, 1'b1, 32'hA5000050);
        expect_cyc("t4_drop", 2'b10, 2'b01, 1'b1, 32'hA5000050);
        idle_all();
        expect_cyc("t4_p1resp", 2'b00, 2'b10, 1'b1, 32'hA5000051);

        // Reset right after a port 1 read drops its response.
        set_req(1, 1'b1, 1'b0, 1'b0, 16'h0060, '0);
        expect_cyc("t5_rd", 2'b10, 2'b00, 1'b0, '0);
        rst = 1'b1;
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0070, '0);
        set_req(1, 1'b1, 1'b0, 1'b0, 16'h0071, '0);
        expect_cyc("t5_rst", 2'b00, 2'b00, 1'b0, '0);
        expect_cyc("t5_rst2", 2'b00, 2'b00, 1'b0, '0);
        rst = 1'b0;
        expect_cyc("t5_pref", 2'b01, 2'b00, 1'b0, '0);
        idle_all();
        expect_cyc("t5_resp", 2'b00, 2'b01, 1'b1, 32'hA5000070);

        // Random traffic on 0x80..0x8F against the shadow scoreboard.
        for (int i = 0; i < 16; i++) shadow[i] = init_word(16'h0080 + i);
        pend_v     = 1'b0;
        pend_port  = 1'b0;
        pend_data  = '0;
        last_ready = 2'b00;
        rnd_xfers  = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(req_valid[p] && !last_ready[p])) begin
                    set_req(p, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                            $urandom_range(0, 3) == 0,
                            AW'(16'h0080 + $urandom_range(0, 15)), $urandom);
                end
            end
            @(negedge clk);
            check_eq("rnd_one_grant", 32'(req_ready[0] & req_ready[1]), 32'h0);
            check_eq("rnd_ready_valid", 32'(req_ready & ~req_valid), 32'h0);
            if (pend_v) begin
                check_eq("rnd_resp_port", 32'(resp_valid), pend_port ? 32'h2 : 32'h1);
                check_eq("rnd_resp_data", resp_rdata, pend_data);
            end else begin
                check_eq("rnd_no_resp", 32'(resp_valid), 32'h0);
            end
            if (|req_ready) begin
                logic p;
                logic [3:0] a;
                p         = req_ready[1];
                a         = req_addr[p][3:0];
                pend_data = shadow[a];
                if (req_we[p]) shadow[a] = req_wdata[p];
                pend_v    = 1'b1;
                pend_port = p;
                rnd_xfers++;
            end else begin
                pend_v = 1'b0;
            end
            last_ready = req_ready;
            next_cycle();
        end
        idle_all();
        @(negedge clk);
        if (pend_v) begin
            check_eq("rnd_final_port", 32'(resp_valid), pend_port ? 32'h2 : 32'h1);
            check_eq("rnd_final_data", resp_rdata, pend_data);
        end else begin
            check_eq("rnd_final_none", 32'(resp_valid), 32'h0);
        end
        $display("random phase transfers=%0d", rnd_xfers);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
